jtgng_rom_arb: RTL and testbench

- Shares the single SDRAM read port among four ROM clients: main CPU program ROM, char ROM, scroll ROM and object ROM.
- Each client presents an address. The block detects address changes, schedules one SDRAM read at a time by fixed priority, and returns data with a per-client ok flag.
- The scroll client needs 24-bit data, which the block assembles from two SDRAM reads.
- Sits between the video/CPU fetch logic and the SDRAM controller in the game top level.

---
 rtl/jtgng_rom_arb.sv | 250 +++++++++++++++++++++++++
 tb/tb_jtgng_rom_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_rom_arb.sv
// Four-client ROM arbiter in front of a single SDRAM read port.
// Fixed priority main > char > scr > obj; scroll data is assembled from two reads.
module jtgng_rom_arb #(
    parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [21:0] CHAR_OFFSET = 22'h0A_0000,
    parameter logic [21:0] SCR_OFFSET  = 22'h0A_8000,
    parameter logic [21:0] SCR2_OFFSET = 22'h0B_8000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h0C_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [16:0] main_addr_i,
    output logic [15:0] main_dout_o,
    output logic        main_ok_o,

    input  logic [12:0] char_addr_i,
    output logic [15:0] char_dout_o,
    output logic        char_ok_o,

    input  logic [14:0] scr_addr_i,
    output logic [23:0] scr_dout_o,
    output logic        scr_ok_o,

    input  logic [15:0] obj_addr_i,
    output logic [15:0] obj_dout_o,
    output logic        obj_ok_o,

    output logic        sdram_req_o,
    output logic [21:0] sdram_addr_o,
    input  logic        sdram_ack_i,
    input  logic        data_rdy_i,
    input  logic [15:0] data_read_i
);

    localparam int unsigned SD_AW   = 22;
    localparam int unsigned TAG_W   = 17;
    localparam int unsigned CHAR_AW = 13;
    localparam int unsigned SCR_AW  = 15;
    localparam int unsigned OBJ_AW  = 16;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_ACK   = 3'd1;
    localparam logic [2:0] WAIT_DATA  = 3'd2;
    localparam logic [2:0] WAIT_ACK2  = 3'd3;
    localparam logic [2:0] WAIT_DATA2 = 3'd4;

    localparam logic [1:0] CL_MAIN = 2'd0;
    localparam logic [1:0] CL_CHAR = 2'd1;
    localparam logic [1:0] CL_SCR  = 2'd2;
    localparam logic [1:0] CL_OBJ  = 2'd3;

    logic [2:0]         state_q,    state_d;
    logic               req_q,      req_d;
    logic [SD_AW-1:0]   addr_q,     addr_d;
    logic [1:0]         win_q,      win_d;
    logic [TAG_W-1:0]   tag_q,      tag_d;
    logic [15:0]        scr_lo_q,   scr_lo_d;

    logic [15:0]        main_dout_q, main_dout_d;
    logic [15:0]        char_dout_q, char_dout_d;
    logic [23:0]        scr_dout_q,  scr_dout_d;
    logic [15:0]        obj_dout_q,  obj_dout_d;

    logic [TAG_W-1:0]   main_tag_q, main_tag_d;
    logic [CHAR_AW-1:0] char_tag_q, char_tag_d;
    logic [SCR_AW-1:0]  scr_tag_q,  scr_tag_d;
    logic [OBJ_AW-1:0]  obj_tag_q,  obj_tag_d;
    logic               main_vld_q, main_vld_d;
    logic               char_vld_q, char_vld_d;
    logic               scr_vld_q,  scr_vld_d;
    logic               obj_vld_q,  obj_vld_d;

    logic               main_pend, char_pend, scr_pend, obj_pend;
    logic [7:0]         scr_byte;

    // ok compares against the live address, so it drops as soon as the address moves
    assign main_ok_o = main_vld_q && (main_tag_q == main_addr_i);
    assign char_ok_o = char_vld_q && (char_tag_q == char_addr_i);
    assign scr_ok_o  = scr_vld_q  && (scr_tag_q  == scr_addr_i);
    assign obj_ok_o  = obj_vld_q  && (obj_tag_q  == obj_addr_i);

    assign main_pend = !main_ok_o;
    assign char_pend = !char_ok_o;
    assign scr_pend  = !scr_ok_o;
    assign obj_pend  = !obj_ok_o;

    assign scr_byte = tag_q[0] ? data_read_i[15:8] : data_read_i[7:0];

    assign main_dout_o  = main_dout_q;
    assign char_dout_o  = char_dout_q;
    assign scr_dout_o   = scr_dout_q;
    assign obj_dout_o   = obj_dout_q;
    assign sdram_req_o  = req_q;
    assign sdram_addr_o = addr_q;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        win_d       = win_q;
        tag_d       = tag_q;
        scr_lo_d    = scr_lo_q;
        main_dout_d = main_dout_q;
        char_dout_d = char_dout_q;
        scr_dout_d  = scr_dout_q;
        obj_dout_d  = obj_dout_q;
        main_tag_d  = main_tag_q;
        char_tag_d  = char_tag_q;
        scr_tag_d   = scr_tag_q;
        obj_tag_d   = obj_tag_q;
        main_vld_d  = main_vld_q;
        char_vld_d  = char_vld_q;
        scr_vld_d   = scr_vld_q;
        obj_vld_d   = obj_vld_q;

        case (state_q)
            IDLE: begin
                if (main_pend) begin
                    win_d   = CL_MAIN;
                    tag_d   = main_addr_i;
                    addr_d  = MAIN_OFFSET + SD_AW'(main_addr_i);
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else if (char_pend) begin
                    win_d   = CL_CHAR;
                    tag_d   = TAG_W'(char_addr_i);
                    addr_d  = CHAR_OFFSET + SD_AW'(char_addr_i);
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else if (scr_pend) begin
                    win_d   = CL_SCR;
                    tag_d   = TAG_W'(scr_addr_i);
                    addr_d  = SCR_OFFSET + SD_AW'(scr_addr_i);
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else if (obj_pend) begin
                    win_d   = CL_OBJ;
                    tag_d   = TAG_W'(obj_addr_i);
                    addr_d  = OBJ_OFFSET + SD_AW'(obj_addr_i);
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (sdram_ack_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (data_rdy_i) begin
                    state_d = IDLE;
                    case (win_q)
                        CL_MAIN: begin
                            main_dout_d = data_read_i;
                            main_tag_d  = tag_q;
                            main_vld_d  = 1'b1;
                        end
                        CL_CHAR: begin
                            char_dout_d = data_read_i;
                            char_tag_d  = tag_q[CHAR_AW-1:0];
                            char_vld_d  = 1'b1;
                        end
                        CL_SCR: begin
                            // planes 0/1 staged; plane 2 lives in a byte-packed region
                            scr_lo_d = data_read_i;
                            addr_d   = SCR2_OFFSET + {8'd0, tag_q[14:1]};
                            req_d    = 1'b1;
                            state_d  = WAIT_ACK2;
                        end
                        default: begin
                            obj_dout_d = data_read_i;
                            obj_tag_d  = tag_q[OBJ_AW-1:0];
                            obj_vld_d  = 1'b1;
                        end
                    endcase
                end
            end

            WAIT_ACK2: begin
                if (sdram_ack_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DATA2;
                end
            end

            WAIT_DATA2: begin
                if (data_rdy_i) begin
                    scr_dout_d = {scr_byte, scr_lo_q};
                    scr_tag_d  = tag_q[SCR_AW-1:0];
                    scr_vld_d  = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            win_q       <= CL_MAIN;
            tag_q       <= '0;
            scr_lo_q    <= '0;
            main_dout_q <= '0;
            char_dout_q <= '0;
            scr_dout_q  <= '0;
            obj_dout_q  <= '0;
            main_tag_q  <= '0;
            char_tag_q  <= '0;
            scr_tag_q   <= '0;
            obj_tag_q   <= '0;
            main_vld_q  <= 1'b0;
            char_vld_q  <= 1'b0;
            scr_vld_q   <= 1'b0;
            obj_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            win_q       <= win_d;
            tag_q       <= tag_d;
            scr_lo_q    <= scr_lo_d;
            main_dout_q <= main_dout_d;
            char_dout_q <= char_dout_d;
            scr_dout_q  <= scr_dout_d;
            obj_dout_q  <= obj_dout_d;
            main_tag_q  <= main_tag_d;
            char_tag_q  <= char_tag_d;
            scr_tag_q   <= scr_tag_d;
            obj_tag_q   <= obj_tag_d;
            main_vld_q  <= main_vld_d;
            char_vld_q  <= char_vld_d;
            scr_vld_q   <= scr_vld_d;
            obj_vld_q   <= obj_vld_d;
        end
    end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// Directed bench for jtgng_rom_arb: table of single-client transactions
// plus hand-written sequences for startup, collisions, in-flight changes and reset.
module tb_jtgng_rom_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] main_addr;
    logic [15:0] main_dout;
    logic        main_ok;
    logic [12:0] char_addr;
    logic [15:0] char_dout;
    logic        char_ok;
    logic [14:0] scr_addr;
    logic [23:0] scr_dout;
    logic        scr_ok;
    logic [15:0] obj_addr;
    logic [15:0] obj_dout;
    logic        obj_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] data_read;

    always #5 clk = ~clk;

    jtgng_rom_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .main_addr_i  (main_addr),
        .main_dout_o  (main_dout),
        .main_ok_o    (main_ok),
        .char_addr_i  (char_addr),
        .char_dout_o  (char_dout),
        .char_ok_o    (char_ok),
        .scr_addr_i   (scr_addr),
        .scr_dout_o   (scr_dout),
        .scr_ok_o     (scr_ok),
        .obj_addr_i   (obj_addr),
        .obj_dout_o   (obj_dout),
        .obj_ok_o     (obj_ok),
        .sdram_req_o  (sdram_req),
        .sdram_addr_o (sdram_addr),
        .sdram_ack_i  (sdram_ack),
        .data_rdy_i   (data_rdy),
        .data_read_i  (data_read)
    );

    typedef struct {
        int          client;
        logic [16:0] addr;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [21:0] a1;
        logic [21:0] a2;
        logic [23:0] dout;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] mdl_dout [4];
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ok(input int c);
        case (c)
            0:       return main_ok;
            1:       return char_ok;
            2:       return scr_ok;
            default: return obj_ok;
        endcase
    endfunction

    function automatic logic [23:0] get_dout(input int c);
        case (c)
            0:       return 24'(main_dout);
            1:       return 24'(char_dout);
            2:       return scr_dout;
            default: return 24'(obj_dout);
        endcase
    endfunction

    task automatic set_addr(input int c, input logic [16:0] a);
        case (c)
            0:       main_addr = a;
            1:       char_addr = a[12:0];
            2:       scr_addr  = a[14:0];
            default: obj_addr  = a[15:0];
        endcase
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s req", name), 32'(sdram_req), 32'd1);
    endtask

    task automatic do_ack(input string name, input int dly);
        repeat (dly) @(negedge clk);
        chk($sformatf("%s req held", name), 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk($sformatf("%s req drop", name), 32'(sdram_req), 32'd0);
    endtask

    task automatic do_rdy(input int dly, input logic [15:0] d);
        repeat (dly) @(negedge clk);
        data_read = d;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input string name, input logic [21:0] a, input logic [15:0] d,
                         input int ack_dly, input int rdy_dly);
        wait_req(name);
        chk($sformatf("%s addr", name), 32'(sdram_addr), 32'(a));
        do_ack(name, ack_dly);
        do_rdy(rdy_dly, d);
    endtask

    task automatic chk_all(input string name);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s ok%0d", name, c), 32'(get_ok(c)), 32'd1);
            chk($sformatf("%s dout%0d", name, c), 32'(get_dout(c)), 32'(mdl_dout[c]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 17'h00155, 16'hBEEF, 16'h0000, 22'h0A_0155, 22'h0, 24'h00BEEF};
        vecs[1] = '{2, 17'h00003, 16'hA5A5, 16'h7E11, 22'h0A_8003, 22'h0B_8001, 24'h7EA5A5};
        vecs[2] = '{0, 17'h12345, 16'hCAFE, 16'h0000, 22'h01_2345, 22'h0, 24'h00CAFE};
        vecs[3] = '{3, 17'h0FFFF, 16'h0F0F, 16'h0000, 22'h0C_FFFF, 22'h0, 24'h000F0F};
        vecs[4] = '{2, 17'h07FFE, 16'h1111, 16'h2233, 22'h0A_FFFE, 22'h0B_BFFF, 24'h331111};
        vecs[5] = '{1, 17'h01FFF, 16'h0001, 16'h0000, 22'h0A_1FFF, 22'h0, 24'h000001};
        vecs[6] = '{2, 17'h04001, 16'h0102, 16'hABCD, 22'h0A_C001, 22'h0B_A000, 24'hAB0102};

        rst_n = 1'b0;
        main_addr = '0; char_addr = '0; scr_addr = '0; obj_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst req", 32'(sdram_req), 32'd0);
        chk("rst addr", 32'(sdram_addr), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst ok%0d", c), 32'(get_ok(c)), 32'd0);
            chk($sformatf("rst dout%0d", c), 32'(get_dout(c)), 32'd0);
        end

        // startup: every client pending, served strictly by priority
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1 req latency", 32'(sdram_req), 32'd1);
        serve("t1 main", 22'h00_0000, 16'h1234, 2, 4);
        chk("t1 main ok", 32'(main_ok), 32'd1);
        chk("t1 main dout", 32'(main_dout), 32'h1234);
        serve("t1 char", 22'h0A_0000, 16'h1234, 2, 4);
        chk("t1 char ok", 32'(char_ok), 32'd1);
        serve("t1 scr1", 22'h0A_8000, 16'h1234, 2, 4);
        chk("t1 scr ok early", 32'(scr_ok), 32'd0);
        serve("t1 scr2", 22'h0B_8000, 16'h1234, 2, 4);
        chk("t1 scr ok", 32'(scr_ok), 32'd1);
        chk("t1 scr dout", 32'(scr_dout), 32'h341234);
        serve("t1 obj", 22'h0C_0000, 16'h1234, 2, 4);
        mdl_dout[0] = 24'h001234;
        mdl_dout[1] = 24'h001234;
        mdl_dout[2] = 24'h341234;
        mdl_dout[3] = 24'h001234;
        chk_all("t1 end");

        // table of single-client transactions
        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            set_addr(vecs[i].client, vecs[i].addr);
            #1;
            chk($sformatf("%s ok drop", nm), 32'(get_ok(vecs[i].client)), 32'd0);
            serve(nm, vecs[i].a1, vecs[i].d1, i % 3, 1 + i % 2);
            if (vecs[i].client == 2) begin
                chk($sformatf("%s ok mid", nm), 32'(scr_ok), 32'd0);
                chk($sformatf("%s dout mid", nm), 32'(scr_dout), 32'(mdl_dout[2]));
                serve($sformatf("%s second", nm), vecs[i].a2, vecs[i].d2, 1, 2);
            end
            mdl_dout[vecs[i].client] = vecs[i].dout;
            chk_all(nm);
        end

        // main and obj change together: main first, obj right after
        main_addr = 17'h00100;
        obj_addr  = 16'h0200;
        #1;
        chk("t4 main ok drop", 32'(main_ok), 32'd0);
        chk("t4 obj ok drop", 32'(obj_ok), 32'd0);
        serve("t4 main", 22'h00_0100, 16'h4444, 1, 1);
        chk("t4 main ok", 32'(main_ok), 32'd1);
        chk("t4 obj ok wait", 32'(obj_ok), 32'd0);
        chk("t4 idle gap", 32'(sdram_req), 32'd0);
        @(negedge clk);
        chk("t4 obj req", 32'(sdram_req), 32'd1);
        serve("t4 obj", 22'h0C_0200, 16'h5555, 1, 1);
        mdl_dout[0] = 24'h004444;
        mdl_dout[3] = 24'h005555;
        chk_all("t4 end");

        // char address moves while its read is in flight
        char_addr = 13'h0010;
        wait_req("t5 old");
        chk("t5 old addr", 32'(sdram_addr), 32'h0A_0010);
        do_ack("t5 old", 1);
        char_addr = 13'h0011;
        #1;
        chk("t5 ok in flight", 32'(char_ok), 32'd0);
        do_rdy(2, 16'h5A5A);
        chk("t5 stale dout", 32'(char_dout), 32'h5A5A);
        chk("t5 stale ok", 32'(char_ok), 32'd0);
        serve("t5 new", 22'h0A_0011, 16'h6666, 1, 1);
        mdl_dout[1] = 24'h006666;
        chk_all("t5 end");

        // reset in WAIT_DATA, then a late data_rdy
        obj_addr = 16'h1234;
        wait_req("t6");
        chk("t6 addr", 32'(sdram_addr), 32'h0C_1234);
        do_ack("t6", 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6 rst req", 32'(sdram_req), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t6 rst ok%0d", c), 32'(get_ok(c)), 32'd0);
            chk($sformatf("t6 rst dout%0d", c), 32'(get_dout(c)), 32'd0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        data_read = 16'hFFFF;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t6 late ok%0d", c), 32'(get_ok(c)), 32'd0);
            chk($sformatf("t6 late dout%0d", c), 32'(get_dout(c)), 32'd0);
        end
        chk("t6 rerequest", 32'(sdram_req), 32'd1);
        chk("t6 rerequest addr", 32'(sdram_addr), 32'h00_0100);
        serve("t6 main", 22'h00_0100, 16'h9999, 1, 1);
        chk("t6 main ok", 32'(main_ok), 32'd1);
        chk("t6 main dout", 32'(main_dout), 32'h9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
